regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/rv_wb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv_wb_pkg.sv
// Shared definitions for the register-file writeback slice.
//   REG_IDX_W    : register index width
//   REG_ZERO     : hard-wired zero register index (writes are discarded)
//   lock_state_e : key-register lock FSM states
package rv_wb_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

endpackage : rv_wb_pkg

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i[1:0] : requests (bit 0 = ALU, bit 1 = MEM)
//   gnt_o[1:0] : one-hot grant, combinational
// The pointer names the requester that wins the next contended cycle. It
// only moves on contention, and then to the loser.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic rr_q, rr_d;

    always_comb begin
        gnt_o = req_i;
        rr_d  = rr_q;
        if (req_i == 2'b11) begin
            gnt_o = rr_q ? 2'b10 : 2'b01;
            rr_d  = ~rr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule : rr_arb2

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of a single register-file write port.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   alu_valid/addr/data, alu_ready  : ALU writeback handshake
//   mem_valid/addr/data, mem_ready  : load-unit writeback handshake
//   lock_set                        : pulse that write-protects KEY_ADDR
//   wr_en/wr_addr/wr_data           : registered write port, one cycle after accept
//   locked                          : key register is write-protected
//   violation, viol_count           : sticky flag / saturating count of blocked writes
module regfile_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter logic [REG_IDX_W-1:0] KEY_ADDR = 5'd31,
    parameter int unsigned          VIOL_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_addr,
    input  logic [31:0]          alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_addr,
    input  logic [31:0]          mem_data,
    output logic                 mem_ready,
    input  logic                 lock_set,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] wr_addr,
    output logic [31:0]          wr_data,
    output logic                 locked,
    output logic                 violation,
    output logic [VIOL_W-1:0]    viol_count
);

    logic [1:0]           gnt;
    logic                 accept;
    logic                 key_hit;
    logic [REG_IDX_W-1:0] sel_addr;
    logic [31:0]          sel_data;

    lock_state_e          lock_q;
    logic                 wr_en_q, wr_en_d;
    logic [REG_IDX_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 viol_q, viol_d;
    logic [VIOL_W-1:0]    viol_cnt_q, viol_cnt_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({mem_valid, alu_valid}),
        .gnt_o (gnt)
    );

    // Nothing is accepted while reset is held.
    assign alu_ready = gnt[0] & rst_n;
    assign mem_ready = gnt[1] & rst_n;

    always_comb begin
        accept     = alu_ready | mem_ready;
        sel_addr   = mem_ready ? mem_addr : alu_addr;
        sel_data   = mem_ready ? mem_data : alu_data;
        // Lock is checked against the current state, so a key write in the
        // same cycle as lock_set still commits.
        key_hit    = accept && (lock_q == LOCK_LOCKED) && (sel_addr == KEY_ADDR);
        wr_en_d    = accept && (sel_addr != REG_ZERO) && !key_hit;
        wr_addr_d  = accept ? sel_addr : wr_addr_q;
        wr_data_d  = accept ? sel_data : wr_data_q;
        viol_d     = viol_q | key_hit;
        viol_cnt_d = viol_cnt_q;
        if (key_hit && (viol_cnt_q != '1)) begin
            viol_cnt_d = viol_cnt_q + VIOL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            viol_q     <= 1'b0;
            viol_cnt_q <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            viol_q     <= viol_d;
            viol_cnt_q <= viol_cnt_d;
        end
    end

    // Lock FSM: LOCKED is terminal until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= LOCK_UNLOCKED;
        end else begin
            case (lock_q)
                LOCK_UNLOCKED: if (lock_set) lock_q <= LOCK_LOCKED;
                LOCK_LOCKED:   lock_q <= LOCK_LOCKED;
                default:       lock_q <= LOCK_UNLOCKED;
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign locked     = (lock_q == LOCK_LOCKED);
    assign violation  = viol_q;
    assign viol_count = viol_cnt_q;

endmodule : regfile_wb_arbiter
